// File: rtl/des40_pkg.sv
`default_nettype none
// ============================================================================
// Module      : des40_pkg
// Description : Shared definitions for the 40 MHz frame aligner. Holds the
//               aligner state encoding, the default frame parameters and a
//               helper that extracts the byte at a given bit offset from a
//               16-bit window. The deserializer testbench uses it too.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package des40_pkg;

   // Aligner FSM state encoding
   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } align_state_e;

   // Default frame format
   localparam logic [7:0] DEF_SYNC_BYTE  = 8'hBC;
   localparam int         DEF_FRAME_LEN  = 16;
   localparam int         DEF_LOCK_COUNT = 3;
   localparam int         DEF_LOSS_COUNT = 4;

   // Byte starting at bit k of a {newer, older} window. Because the stream
   // arrives LSB first, the older byte sits in the low half of the window.
   function automatic logic [7:0] window_byte(input logic [15:0] window,
                                              input logic [2:0]  k);
      logic [15:0] shifted;
      shifted = window >> k;
      return shifted[7:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_search.sv
`default_nettype none
// ============================================================================
// Module      : sync_search
// Description : Combinational sync-pattern search over all eight bit offsets
//               of a 16-bit window. Reports every offset that matches, a
//               summary flag, and the lowest matching offset.
// Ports       : window       in  [15:0] {current byte, previous byte}
//               sync_pattern in  [7:0]  pattern to look for
//               match_vec    out [7:0]  bit k set when window[k+7:k] matches
//               match_any    out        any offset matches
//               match_off    out [2:0]  lowest matching offset (0 if none)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_search (
   input  logic [15:0] window,
   input  logic [7:0]  sync_pattern,
   output logic [7:0]  match_vec,
   output logic        match_any,
   output logic [2:0]  match_off
);

   genvar k;
   generate
      for (k = 0; k < 8; k++) begin : g_off
         assign match_vec[k] = (window[k+7:k] == sync_pattern);
      end
   endgenerate

   assign match_any = |match_vec;

   // Scan from the top down so the lowest matching offset wins.
   always_comb begin
      match_off = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (match_vec[i]) begin
            match_off = 3'(i);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/frame_align_40.sv
`default_nettype none
// ============================================================================
// Module      : frame_align_40
// Description : Byte/bit frame aligner. Hunts for the sync byte at any of
//               eight bit offsets, confirms it over LOCK_COUNT frames, then
//               emits realigned payload bytes until LOSS_COUNT consecutive
//               syncs are missed.
// Ports       : clock_40      in        single clock, rising edge
//               reset_n       in        asynchronous active-low reset
//               byte_in       in  [7:0] deserializer byte, LSB received first
//               byte_valid    in        strobe qualifying byte_in
//               payload_out   out [7:0] aligned payload byte (held when idle)
//               payload_valid out       strobe qualifying payload_out
//               frame_start   out       first payload byte of a frame
//               locked        out       aligner is in LOCKED
//               bit_offset    out [2:0] current alignment offset
// Revision    : 1.0 - initial release
// ============================================================================
module frame_align_40
   import des40_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE  = DEF_SYNC_BYTE,
   parameter int         FRAME_LEN  = DEF_FRAME_LEN,
   parameter int         LOCK_COUNT = DEF_LOCK_COUNT,
   parameter int         LOSS_COUNT = DEF_LOSS_COUNT
) (
   input  logic       clock_40,
   input  logic       reset_n,
   input  logic [7:0] byte_in,
   input  logic       byte_valid,
   output logic [7:0] payload_out,
   output logic       payload_valid,
   output logic       frame_start,
   output logic       locked,
   output logic [2:0] bit_offset
);

   // Counter widths: pos only reaches FRAME_LEN-1, the good/miss counters
   // must be able to hold their limit value itself.
   localparam int POS_W  = $clog2(FRAME_LEN);
   localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
   localparam int MISS_W = $clog2(LOSS_COUNT + 1);

   localparam logic [POS_W-1:0]  POS_LAST   = POS_W'(FRAME_LEN - 1);
   localparam logic [POS_W-1:0]  POS_FIRST  = POS_W'(1);
   localparam logic [GOOD_W-1:0] GOOD_LIMIT = GOOD_W'(LOCK_COUNT);
   localparam logic [GOOD_W-1:0] GOOD_ONE   = GOOD_W'(1);
   localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'(LOSS_COUNT);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   align_state_e      state_q,         state_d;
   logic [POS_W-1:0]  pos_q,           pos_d;
   logic [GOOD_W-1:0] good_cnt_q,      good_cnt_d;
   logic [MISS_W-1:0] miss_cnt_q,      miss_cnt_d;
   logic [7:0]        prev_byte_q,     prev_byte_d;
   logic              prev_valid_q,    prev_valid_d;
   logic [2:0]        bit_offset_q,    bit_offset_d;
   logic [7:0]        payload_q,       payload_d;
   logic              payload_valid_q, payload_valid_d;
   logic              frame_start_q,   frame_start_d;
   logic              locked_q,        locked_d;

   // ------------------------------------------------------------------
   // Window, search and helpers
   // ------------------------------------------------------------------
   logic [15:0]       window;
   logic [7:0]        match_vec;
   logic              match_any;
   logic [2:0]        match_off;
   logic              sync_ok;
   logic [7:0]        aligned;
   logic [POS_W-1:0]  pos_inc;
   logic [GOOD_W-1:0] good_inc;
   logic [MISS_W-1:0] miss_inc;
   logic              do_search;

   assign window = {byte_in, prev_byte_q};

   sync_search u_sync_search (
      .window       (window),
      .sync_pattern (SYNC_BYTE),
      .match_vec    (match_vec),
      .match_any    (match_any),
      .match_off    (match_off)
   );

   // Once an offset is captured, only that offset is trusted.
   assign sync_ok  = match_vec[bit_offset_q];
   assign aligned  = window_byte(window, bit_offset_q);
   assign pos_inc  = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
   assign good_inc = good_cnt_q + 1'b1;
   assign miss_inc = miss_cnt_q + 1'b1;

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d         = state_q;
      pos_d           = pos_q;
      good_cnt_d      = good_cnt_q;
      miss_cnt_d      = miss_cnt_q;
      prev_byte_d     = prev_byte_q;
      prev_valid_d    = prev_valid_q;
      bit_offset_d    = bit_offset_q;
      payload_d       = payload_q;
      payload_valid_d = 1'b0;
      frame_start_d   = 1'b0;
      do_search       = 1'b0;

      if (byte_valid) begin
         prev_byte_d  = byte_in;
         prev_valid_d = 1'b1;

         // The first byte after reset only primes the window.
         if (prev_valid_q) begin
            case (state_q)
               HUNT: begin
                  do_search = 1'b1;
               end

               CHECK: begin
                  pos_d = pos_inc;
                  if (pos_q == '0) begin
                     if (sync_ok) begin
                        good_cnt_d = good_inc;
                        if (good_inc == GOOD_LIMIT) begin
                           state_d    = LOCKED;
                           miss_cnt_d = '0;
                        end
                     end else begin
                        // Rejected: re-search this very byte.
                        do_search = 1'b1;
                     end
                  end
               end

               LOCKED: begin
                  pos_d = pos_inc;
                  if (pos_q == '0) begin
                     // Sync slot is never emitted, matched or not.
                     if (sync_ok) begin
                        miss_cnt_d = '0;
                     end else begin
                        miss_cnt_d = miss_inc;
                        if (miss_inc == MISS_LIMIT) begin
                           state_d    = HUNT;
                           pos_d      = '0;
                           good_cnt_d = '0;
                           miss_cnt_d = '0;
                        end
                     end
                  end else begin
                     payload_d       = aligned;
                     payload_valid_d = 1'b1;
                     frame_start_d   = (pos_q == POS_FIRST);
                  end
               end

               default: begin
                  state_d = HUNT;
               end
            endcase

            if (do_search) begin
               if (match_any) begin
                  bit_offset_d = match_off;
                  pos_d        = POS_FIRST;
                  good_cnt_d   = GOOD_ONE;
                  state_d      = CHECK;
               end else begin
                  pos_d        = '0;
                  good_cnt_d   = '0;
                  state_d      = HUNT;
               end
            end
         end
      end

      locked_d = (state_d == LOCKED);
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clock_40 or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= HUNT;
         pos_q           <= '0;
         good_cnt_q      <= '0;
         miss_cnt_q      <= '0;
         prev_byte_q     <= 8'd0;
         prev_valid_q    <= 1'b0;
         bit_offset_q    <= 3'd0;
         payload_q       <= 8'd0;
         payload_valid_q <= 1'b0;
         frame_start_q   <= 1'b0;
         locked_q        <= 1'b0;
      end else begin
         state_q         <= state_d;
         pos_q           <= pos_d;
         good_cnt_q      <= good_cnt_d;
         miss_cnt_q      <= miss_cnt_d;
         prev_byte_q     <= prev_byte_d;
         prev_valid_q    <= prev_valid_d;
         bit_offset_q    <= bit_offset_d;
         payload_q       <= payload_d;
         payload_valid_q <= payload_valid_d;
         frame_start_q   <= frame_start_d;
         locked_q        <= locked_d;
      end
   end

   assign payload_out   = payload_q;
   assign payload_valid = payload_valid_q;
   assign frame_start   = frame_start_q;
   assign locked        = locked_q;
   assign bit_offset    = bit_offset_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_align_40.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_align_40
// Description : Self-checking bench for frame_align_40. Builds LSB-first bit
//               streams of frames, packs them into bytes at a chosen bit
//               delay and compares every cycle against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_align_40;

   localparam logic [7:0] SYNC = 8'hBC;
   localparam int         FL   = 16;
   localparam int         LC   = 3;
   localparam int         LS   = 4;
   localparam int         S_HUNT = 0, S_CHECK = 1, S_LOCKED = 2;

   logic       clock_40 = 1'b0;
   logic       reset_n;
   logic [7:0] byte_in;
   logic       byte_valid;
   logic [7:0] payload_out;
   logic       payload_valid;
   logic       frame_start;
   logic       locked;
   logic [2:0] bit_offset;

   frame_align_40 #(
      .SYNC_BYTE  (SYNC),
      .FRAME_LEN  (FL),
      .LOCK_COUNT (LC),
      .LOSS_COUNT (LS)
   ) dut (
      .clock_40      (clock_40),
      .reset_n       (reset_n),
      .byte_in       (byte_in),
      .byte_valid    (byte_valid),
      .payload_out   (payload_out),
      .payload_valid (payload_valid),
      .frame_start   (frame_start),
      .locked        (locked),
      .bit_offset    (bit_offset)
   );

   always #5 clock_40 = ~clock_40;

   int n_total;
   int n_pass;

   // Reference model state
   int         m_state, m_pos, m_good, m_miss;
   logic [2:0] m_off;
   logic [7:0] m_prev;
   bit         m_pv;
   logic [7:0] e_payload;
   bit         e_pv, e_fs;

   logic [13:0] obs, exp_v;
   logic [7:0]  got[$];
   bit          lk[$];
   int          idle_pv;

   bit          bits[$];
   logic [7:0]  strm[$];
   logic [7:0]  pay [0:31][1:15];
   logic [7:0]  ref_pay[$];

   // ---------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------
   function automatic int find_sync(input logic [15:0] w);
      for (int k = 0; k < 8; k++) begin
         if (8'(w >> k) == SYNC) return k;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_state = S_HUNT; m_pos = 0; m_good = 0; m_miss = 0; m_off = 3'd0;
      m_prev = 8'd0; m_pv = 1'b0; e_payload = 8'd0; e_pv = 1'b0; e_fs = 1'b0;
   endtask

   task automatic model_byte(input logic [7:0] b);
      logic [15:0] w;
      int          k;
      bit          hunt;
      w = {b, m_prev};
      e_pv = 1'b0; e_fs = 1'b0; hunt = 1'b0;
      if (m_pv) begin
         if (m_state == S_HUNT) begin
            hunt = 1'b1;
         end else if (m_state == S_CHECK) begin
            if (m_pos == 0 && 8'(w >> m_off) != SYNC) begin
               hunt = 1'b1;
            end else begin
               if (m_pos == 0) begin
                  m_good++;
                  if (m_good >= LC) begin m_state = S_LOCKED; m_miss = 0; end
               end
               m_pos = (m_pos + 1) % FL;
            end
         end else begin
            if (m_pos == 0) begin
               if (8'(w >> m_off) == SYNC) m_miss = 0; else m_miss++;
            end else begin
               e_pv = 1'b1; e_payload = 8'(w >> m_off); e_fs = (m_pos == 1);
            end
            if (m_miss >= LS) begin
               m_state = S_HUNT; m_miss = 0; m_pos = 0;
            end else begin
               m_pos = (m_pos + 1) % FL;
            end
         end
         if (hunt) begin
            k = find_sync(w);
            if (k >= 0) begin
               m_off = 3'(k); m_pos = 1; m_good = 1; m_state = S_CHECK;
            end else begin
               m_state = S_HUNT;
            end
         end
      end
      m_prev = b;
      m_pv   = 1'b1;
   endtask

   // ---------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------
   task automatic step(input logic [7:0] b, input bit v);
      @(negedge clock_40);
      byte_in    = b;
      byte_valid = v;
      @(posedge clock_40);
      if (v) model_byte(b);
      else begin e_pv = 1'b0; e_fs = 1'b0; end
      #1;
      obs   = {payload_valid, frame_start, locked, bit_offset, payload_out};
      exp_v = {e_pv, e_fs, (m_state == S_LOCKED), m_off, e_payload};
      if (payload_valid) got.push_back(payload_out);
      if (v) lk.push_back(locked);
      else if (payload_valid) idle_pv++;
   endtask

   task automatic do_reset();
      byte_valid = 1'b0;
      reset_n    = 1'b0;
      model_reset();
      repeat (2) @(posedge clock_40);
      @(negedge clock_40);
      reset_n = 1'b1;
      got.delete(); lk.delete(); idle_pv = 0;
   endtask

   task automatic gen_payload(input int nfr, input bit wide);
      for (int f = 0; f < nfr; f++)
         for (int i = 1; i < FL; i++)
            pay[f][i] = wide ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 31));
   endtask

   task automatic push_byte(input logic [7:0] b);
      for (int j = 0; j < 8; j++) bits.push_back(b[j]);
   endtask

   // Narrow payload (0..31) cannot form the sync pattern at any offset, even
   // across the sync byte boundary, so directed lock timing is exact.
   task automatic build(input int delay, input int nfr, input logic [31:0] corrupt,
                        input int prefix_len, input int false_at);
      bits.delete(); strm.delete();
      repeat (delay) bits.push_back(1'b0);
      for (int i = 0; i < prefix_len; i++)
         push_byte((i == false_at) ? SYNC : 8'($urandom_range(0, 31)));
      for (int f = 0; f < nfr; f++) begin
         push_byte(corrupt[f] ? 8'h00 : SYNC);
         for (int i = 1; i < FL; i++) push_byte(pay[f][i]);
      end
      repeat (16) bits.push_back(1'b0);
      while (bits.size() % 8 != 0) bits.push_back(1'b0);
      for (int i = 0; i < bits.size() / 8; i++) begin
         logic [7:0] b;
         for (int j = 0; j < 8; j++) b[j] = bits[8*i+j];
         strm.push_back(b);
      end
   endtask

   // ---------------------------------------------------------------
   // Tests
   // ---------------------------------------------------------------
   task automatic test_reset();
      byte_valid = 1'b0; byte_in = 8'd0; reset_n = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clock_40);
         byte_in = SYNC; byte_valid = 1'b1;
         @(posedge clock_40); #1;
         obs = {payload_valid, frame_start, locked, bit_offset, payload_out};
         n_total++;
         if (obs !== 14'd0) $display("FAIL reset_hold cycle %0d: got %h expected 0", i, obs);
         else n_pass++;
      end
      @(negedge clock_40);
      byte_valid = 1'b0;
      reset_n = 1'b1;
      got.delete(); lk.delete(); idle_pv = 0;
      // 0x2F over a zero prev byte would look like sync at offset 6 if the
      // first byte were searched rather than only loaded.
      step(8'h2F, 1'b1);
      n_total++;
      if (bit_offset !== 3'd0) $display("FAIL first_byte_only_loads: got %0d expected 0", bit_offset);
      else n_pass++;
      step(8'h00, 1'b1);
      n_total++;
      if (obs !== exp_v) $display("FAIL after_reset: got %h expected %h", obs, exp_v);
      else n_pass++;
   endtask

   task automatic test_clean_lock();
      do_reset();
      gen_payload(8, 1'b0);
      build(0, 8, 32'd0, 0, -1);
      foreach (strm[i]) begin
         step(strm[i], 1'b1);
         n_total++;
         if (obs !== exp_v) $display("FAIL clean_lock step %0d: got %h expected %h", i, obs, exp_v);
         else n_pass++;
      end
      step(8'h00, 1'b0);
      ref_pay.delete();
      for (int f = 2; f < 8; f++)
         for (int i = 1; i < FL; i++) ref_pay.push_back(pay[f][i]);
      n_total++;
      if (lk[32] !== 1'b0 || lk[33] !== 1'b1)
         $display("FAIL clean_lock_timing: got %b%b expected 01", lk[32], lk[33]);
      else n_pass++;
      n_total++;
      if (bit_offset !== 3'd0) $display("FAIL clean_offset: got %0d expected 0", bit_offset);
      else n_pass++;
      n_total++;
      if (got.size() < ref_pay.size())
         $display("FAIL clean_payload_count: got %0d expected %0d", got.size(), ref_pay.size());
      else n_pass++;
      foreach (ref_pay[i]) begin
         n_total++;
         if (i >= got.size() || got[i] !== ref_pay[i])
            $display("FAIL clean_payload %0d: got %h expected %h", i, (i < got.size()) ? got[i] : 8'hxx, ref_pay[i]);
         else n_pass++;
      end
   endtask

   task automatic test_bit_offset();
      do_reset();
      build(5, 8, 32'd0, 0, -1);
      foreach (strm[i]) begin
         step(strm[i], 1'b1);
         n_total++;
         if (obs !== exp_v) $display("FAIL bit_offset step %0d: got %h expected %h", i, obs, exp_v);
         else n_pass++;
      end
      step(8'h00, 1'b0);
      n_total++;
      if (bit_offset !== 3'd5) $display("FAIL offset5_value: got %0d expected 5", bit_offset);
      else n_pass++;
      n_total++;
      if (lk[32] !== 1'b0 || lk[33] !== 1'b1)
         $display("FAIL offset5_lock_timing: got %b%b expected 01", lk[32], lk[33]);
      else n_pass++;
      foreach (ref_pay[i]) begin
         n_total++;
         if (i >= got.size() || got[i] !== ref_pay[i])
            $display("FAIL offset5_payload %0d: got %h expected %h", i, (i < got.size()) ? got[i] : 8'hxx, ref_pay[i]);
         else n_pass++;
      end
   endtask

   task automatic test_gaps();
      do_reset();
      build(0, 8, 32'd0, 0, -1);
      foreach (strm[i]) begin
         step(strm[i], 1'b1);
         n_total++;
         if (obs !== exp_v) $display("FAIL gaps valid step %0d: got %h expected %h", i, obs, exp_v);
         else n_pass++;
         for (int g = 0; g < 7; g++) begin
            step(8'($urandom_range(0, 255)), 1'b0);
            n_total++;
            if (obs !== exp_v) $display("FAIL gaps idle step %0d: got %h expected %h", i, obs, exp_v);
            else n_pass++;
         end
      end
      n_total++;
      if (idle_pv !== 0) $display("FAIL gaps_idle_valid: got %0d expected 0", idle_pv);
      else n_pass++;
      foreach (ref_pay[i]) begin
         n_total++;
         if (i >= got.size() || got[i] !== ref_pay[i])
            $display("FAIL gaps_payload %0d: got %h expected %h", i, (i < got.size()) ? got[i] : 8'hxx, ref_pay[i]);
         else n_pass++;
      end
   endtask

   task automatic test_false_sync();
      do_reset();
      gen_payload(6, 1'b0);
      // Ten leading payload bytes, a false sync at the fourth.
      build(2, 6, 32'd0, 10, 3);
      foreach (strm[i]) begin
         step(strm[i], 1'b1);
         n_total++;
         if (obs !== exp_v) $display("FAIL false_sync step %0d: got %h expected %h", i, obs, exp_v);
         else n_pass++;
      end
      step(8'h00, 1'b0);
      n_total++;
      if (lk[58] !== 1'b0 || lk[59] !== 1'b1)
         $display("FAIL false_sync_relock: got %b%b expected 01", lk[58], lk[59]);
      else n_pass++;
      n_total++;
      if (bit_offset !== 3'd2) $display("FAIL false_sync_offset: got %0d expected 2", bit_offset);
      else n_pass++;
   endtask

   task automatic test_loss();
      logic [31:0] mask;
      do_reset();
      gen_payload(18, 1'b0);
      mask = '0;
      mask[5] = 1'b1; mask[6] = 1'b1; mask[7] = 1'b1;
      mask[9] = 1'b1; mask[10] = 1'b1; mask[11] = 1'b1; mask[12] = 1'b1;
      build(3, 18, mask, 0, -1);
      foreach (strm[i]) begin
         step(strm[i], 1'b1);
         n_total++;
         if (obs !== exp_v) $display("FAIL loss step %0d: got %h expected %h", i, obs, exp_v);
         else n_pass++;
      end
      step(8'h00, 1'b0);
      n_total++;
      if (lk[113] !== 1'b1 || lk[129] !== 1'b1)
         $display("FAIL loss_three_misses: got %b%b expected 11", lk[113], lk[129]);
      else n_pass++;
      n_total++;
      if (lk[192] !== 1'b1 || lk[193] !== 1'b0)
         $display("FAIL loss_four_misses: got %b%b expected 10", lk[192], lk[193]);
      else n_pass++;
      n_total++;
      if (lk[240] !== 1'b0 || lk[241] !== 1'b1)
         $display("FAIL loss_relock: got %b%b expected 01", lk[240], lk[241]);
      else n_pass++;
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      gen_payload(6, 1'b0);
      build(1, 6, 32'd0, 0, -1);
      for (int i = 0; i <= 71; i++) begin
         step(strm[i], 1'b1);
         n_total++;
         if (obs !== exp_v) $display("FAIL mid_reset pre step %0d: got %h expected %h", i, obs, exp_v);
         else n_pass++;
      end
      #2;
      byte_valid = 1'b0;
      reset_n    = 1'b0;
      #1;
      obs = {payload_valid, frame_start, locked, bit_offset, payload_out};
      n_total++;
      if (obs !== 14'd0) $display("FAIL mid_reset_async: got %h expected 0", obs);
      else n_pass++;
      model_reset();
      repeat (2) @(posedge clock_40);
      @(negedge clock_40);
      reset_n = 1'b1;
      got.delete(); lk.delete();
      gen_payload(5, 1'b0);
      build(4, 5, 32'd0, 0, -1);
      foreach (strm[i]) begin
         step(strm[i], 1'b1);
         n_total++;
         if (obs !== exp_v) $display("FAIL mid_reset post step %0d: got %h expected %h", i, obs, exp_v);
         else n_pass++;
      end
      step(8'h00, 1'b0);
      n_total++;
      if (lk[32] !== 1'b0 || lk[33] !== 1'b1)
         $display("FAIL mid_reset_relock: got %b%b expected 01", lk[32], lk[33]);
      else n_pass++;
   endtask

   task automatic test_random();
      do_reset();
      for (int r = 0; r < 3; r++) begin
         gen_payload(10, 1'b1);
         build($urandom_range(0, 7), 10,
               32'($urandom() & $urandom() & $urandom()),
               $urandom_range(0, 20), -1);
         foreach (strm[i]) begin
            repeat ($urandom_range(0, 2)) begin
               step(8'($urandom_range(0, 255)), 1'b0);
               n_total++;
               if (obs !== exp_v) $display("FAIL random idle r%0d step %0d: got %h expected %h", r, i, obs, exp_v);
               else n_pass++;
            end
            step(strm[i], 1'b1);
            n_total++;
            if (obs !== exp_v) $display("FAIL random r%0d step %0d: got %h expected %h", r, i, obs, exp_v);
            else n_pass++;
         end
      end
      step(8'h00, 1'b0);
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      idle_pv = 0;
      test_reset();
      test_clean_lock();
      test_bit_offset();
      test_gaps();
      test_false_sync();
      test_loss();
      test_reset_mid_frame();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
